// File: rtl/pcie_qos_pkg.sv
// pcie_qos_pkg: shared types and constants for the VC pop arbiter.
package pcie_qos_pkg;
    typedef enum logic {IDLE, ARB} arb_state_t;
    localparam int DEF_DATA_WIDTH = 6;
    localparam logic DEST_D0 = 1'b0;
    localparam logic DEST_D1 = 1'b1;
    localparam int CNT0_W = 3;
endpackage

// File: rtl/vc_pop_arbiter_if.sv
// vc_pop_arbiter_if: VC FIFO heads, destination flags, pop and push strobes.
interface vc_pop_arbiter_if
    import pcie_qos_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic arb_en;
    logic vc0_empty, vc1_empty;
    logic [DATA_WIDTH-1:0] vc0_data, vc1_data;
    logic d0_full, d1_full;
    logic vc0_read, vc1_read;
    logic [DATA_WIDTH-1:0] out_data;
    logic push_d0, push_d1;
    logic vc0_delay;
    modport master (
        input  arb_en, vc0_empty, vc1_empty, vc0_data, vc1_data, d0_full, d1_full,
        output vc0_read, vc1_read, out_data, push_d0, push_d1, vc0_delay
    );
    modport slave (
        output arb_en, vc0_empty, vc1_empty, vc0_data, vc1_data, d0_full, d1_full,
        input  vc0_read, vc1_read, out_data, push_d0, push_d1, vc0_delay
    );
endinterface

// File: rtl/wrr_credit_counter.sv
// wrr_credit_counter: saturating VC0 credit count; vc0_turn while VC0 may still win ties.
module wrr_credit_counter
    import pcie_qos_pkg::*;
#(
    parameter int VC0_WEIGHT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic vc0_turn
);
    localparam logic [CNT0_W-1:0] WMAX = CNT0_W'(VC0_WEIGHT);
    logic [CNT0_W-1:0] cnt0;
    assign vc0_turn = cnt0 < WMAX;
    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt0 <= '0;
        else if (clr)
            cnt0 <= '0;
        else if (inc && vc0_turn)
            cnt0 <= cnt0 + 1'b1;
endmodule

// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter: VC0-weighted round robin popping VC0/VC1 heads into D0/D1.
// Define VC_STATS_EN to add 16-bit grant and VC0-blocked event counters.
module vc_pop_arbiter
    import pcie_qos_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEST_BIT   = DATA_WIDTH - 1,
    parameter int VC0_WEIGHT = 4
) (
    input logic clk,
    input logic reset,
    vc_pop_arbiter_if.master bus
`ifdef VC_STATS_EN
    ,
    output logic [15:0] vc0_grant_cnt,
    output logic [15:0] vc1_grant_cnt,
    output logic [15:0] vc0_blocked_cnt
`endif
);
    arb_state_t state, state_nx;
    logic dest0, dest1, elig0, elig1, gnt0, gnt1, vc0_turn, sel_dest;

    assign dest0 = bus.vc0_data[DEST_BIT];
    assign dest1 = bus.vc1_data[DEST_BIT];
    assign elig0 = !bus.vc0_empty && !(dest0 == DEST_D1 ? bus.d1_full : bus.d0_full);
    assign elig1 = !bus.vc1_empty && !(dest1 == DEST_D1 ? bus.d1_full : bus.d0_full);

    always_ff @(posedge clk or posedge reset)
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx = bus.arb_en ? ARB : IDLE;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == ARB) begin
            gnt0 = elig0 && (!elig1 || vc0_turn);
            gnt1 = elig1 && !gnt0;
        end
    end

    assign bus.vc0_read  = gnt0;
    assign bus.vc1_read  = gnt1;
    assign bus.vc0_delay = !reset && !bus.vc0_empty && !gnt0;
    assign sel_dest      = gnt0 ? dest0 : dest1;

    wrr_credit_counter #(.VC0_WEIGHT(VC0_WEIGHT)) u_credit (
        .clk(clk),
        .reset(reset),
        .inc(gnt0),
        .clr(gnt1),
        .vc0_turn(vc0_turn)
    );

    // Destination room was checked at grant time, so the push is unconditional.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bus.out_data <= '0;
            bus.push_d0  <= 1'b0;
            bus.push_d1  <= 1'b0;
        end else begin
            bus.push_d0 <= (gnt0 || gnt1) && sel_dest == DEST_D0;
            bus.push_d1 <= (gnt0 || gnt1) && sel_dest == DEST_D1;
            if (gnt0 || gnt1)
                bus.out_data <= gnt0 ? bus.vc0_data : bus.vc1_data;
        end

`ifdef VC_STATS_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            vc0_grant_cnt   <= '0;
            vc1_grant_cnt   <= '0;
            vc0_blocked_cnt <= '0;
        end else begin
            vc0_grant_cnt   <= vc0_grant_cnt + {15'd0, gnt0};
            vc1_grant_cnt   <= vc1_grant_cnt + {15'd0, gnt1};
            vc0_blocked_cnt <= vc0_blocked_cnt + {15'd0, bus.vc0_delay};
        end
`endif
endmodule
